// File: rtl/mem_stage.sv
`default_nettype none
// ------------------------------------------------------------------
// mem_stage : load/store stage, single outstanding load, held response
// Rev 1.0
// ------------------------------------------------------------------
module mem_stage #(
  parameter int N = 8,
  parameter int B = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic           req_we,
  input  logic [N-1:0]   req_addr,
  input  logic [4*B-1:0] req_wdata,
  input  logic [4:0]     req_rd,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [4*B-1:0] resp_data,
  output logic [4:0]     resp_rd,
  output logic [N-1:0]   mem_r_addr,
  output logic [N-1:0]   mem_w_addr,
  output logic           mem_r_en,
  output logic           mem_w_en,
  output logic [4*B-1:0] mem_w_data,
  input  logic [4*B-1:0] mem_r_data,
  output logic [15:0]    load_cnt,
  output logic [15:0]    store_cnt,
  output logic [15:0]    stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] tag;
  logic       accept;

  always_comb begin
    req_ready  = 1'b0;
    accept     = 1'b0;
    state_next = IDLE;
    case (state)
      IDLE:    req_ready = 1'b1;
      HOLD:    req_ready = resp_ready;
      default: req_ready = 1'b0;
    endcase
    if (rst) req_ready = 1'b0;
    accept = req_valid & req_ready;
    case (state)
      IDLE:    state_next = (accept & ~req_we) ? WAIT : IDLE;
      WAIT:    state_next = HOLD;
      HOLD: begin
        if (resp_ready) state_next = (accept & ~req_we) ? WAIT : IDLE;
        else            state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_w_en   = accept & req_we;
  assign mem_r_en   = accept & ~req_we;
  assign mem_r_addr = req_addr;
  assign mem_w_addr = req_addr;
  assign mem_w_data = req_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tag        <= 5'd0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= 5'd0;
      load_cnt   <= 16'd0;
      store_cnt  <= 16'd0;
      stall_cnt  <= 16'd0;
    end else begin
      state <= state_next;
      if (accept & ~req_we) tag <= req_rd;
      // Memory registered its read data on the accept edge; capture it one edge later.
      if (state == WAIT) begin
        resp_valid <= 1'b1;
        resp_data  <= mem_r_data;
        resp_rd    <= tag;
      end else if (state == HOLD && resp_ready) begin
        resp_valid <= 1'b0;
      end
      if (accept & ~req_we)        load_cnt  <= load_cnt + 16'd1;
      if (accept & req_we)         store_cnt <= store_cnt + 16'd1;
      if (resp_valid & ~resp_ready) stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire
